// File: rtl/tile16_pkg.sv
// Shared constants, swap FSM state type and tile image contents for the
// 16-tile picture fetch stage.
package tile16_pkg;

  localparam int TILES_PER_ROW = 4;
  localparam int NUM_TILES     = 16;
  localparam int TILE_ID_W     = 4;
  localparam int PAL_IDX_W     = 5;
  localparam int ROM_ADDR_W    = 14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_VB,
    ST_SWAP,
    ST_DONE
  } swap_state_t;

  // Image word for a ROM address {tile_id, row, col}; each tile gets a
  // distinct gradient so tile placement is visible on screen.
  function automatic logic [PAL_IDX_W-1:0] pic_rom_word(input logic [ROM_ADDR_W-1:0] addr);
    logic [7:0] acc;
    acc = 8'd1 + 8'(addr[13:10]) * 8'd7 + 8'(addr[9:5]) + 8'(addr[4:0]) * 8'd3;
    return acc[PAL_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/tile_16_pic_rom.sv
// Tile image ROM: 16 tiles of 32x32 palette indices, one-cycle registered read.
module tile_16_pic_rom
  import tile16_pkg::*;
(
  input  logic                  clk,
  input  logic [ROM_ADDR_W-1:0] addr,
  output logic [PAL_IDX_W-1:0]  data
);

  logic [PAL_IDX_W-1:0] data_q;

  always_ff @(posedge clk) begin
    data_q <= pic_rom_word(addr);
  end

  assign data = data_q;

endmodule

// File: rtl/tile_16_pic_fetch.sv
// Raster-to-palette-index fetch for a 4x4 sliding tile picture, with tile map
// swaps deferred to vertical blanking.
module tile_16_pic_fetch
  import tile16_pkg::*;
#(
  parameter int PIC_X0   = 256,
  parameter int PIC_Y0   = 176,
  parameter int TILE_PX  = 32,
  parameter int V_ACTIVE = 480
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic                 blank,
  input  logic                 swap_req,
  input  logic [3:0]           swap_pos_a,
  input  logic [3:0]           swap_pos_b,
  output logic                 swap_busy,
  output logic                 swap_done,
  output logic [PAL_IDX_W-1:0] pal_index,
  output logic                 blank_out
);

  localparam int TILE_SH = $clog2(TILE_PX);
  localparam int PIC_W   = TILES_PER_ROW * TILE_PX;

  logic [9:0]            rx;
  logic [9:0]            ry;
  logic                  inside_d;
  logic [3:0]            map_pos;
  logic [TILE_ID_W-1:0]  tile_id;
  logic [ROM_ADDR_W-1:0] addr_d;
  logic [ROM_ADDR_W-1:0] addr_q;
  logic                  inside1_q;
  logic                  blank1_q;
  logic                  inside2_q;
  logic                  blank2_q;
  logic [PAL_IDX_W-1:0]  rom_data;

  logic [TILE_ID_W-1:0]  map_q [NUM_TILES];
  logic [TILE_ID_W-1:0]  map_d [NUM_TILES];
  swap_state_t           state_q;
  swap_state_t           state_d;
  logic [3:0]            pos_a_q;
  logic [3:0]            pos_a_d;
  logic [3:0]            pos_b_q;
  logic [3:0]            pos_b_d;

  // Range checks on the raw coordinates so out-of-picture pixels never alias
  // into the grid through subtraction wrap.
  always_comb begin
    rx       = DrawX - 10'(PIC_X0);
    ry       = DrawY - 10'(PIC_Y0);
    inside_d = (32'(DrawX) >= PIC_X0) && (32'(DrawX) < PIC_X0 + PIC_W) &&
               (32'(DrawY) >= PIC_Y0) && (32'(DrawY) < PIC_Y0 + PIC_W);
    map_pos  = {ry[TILE_SH+1:TILE_SH], rx[TILE_SH+1:TILE_SH]};
    tile_id  = map_q[map_pos];
    addr_d   = {tile_id, ry[TILE_SH-1:0], rx[TILE_SH-1:0]};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_q    <= '0;
      inside1_q <= 1'b0;
      blank1_q  <= 1'b0;
      inside2_q <= 1'b0;
      blank2_q  <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      inside1_q <= inside_d;
      blank1_q  <= blank;
      inside2_q <= inside1_q;
      blank2_q  <= blank1_q;
    end
  end

  tile_16_pic_rom u_rom (
    .clk  (Clk),
    .addr (addr_q),
    .data (rom_data)
  );

  assign pal_index = (inside2_q && blank2_q) ? rom_data : '0;
  assign blank_out = blank2_q;

  always_comb begin
    state_d   = state_q;
    pos_a_d   = pos_a_q;
    pos_b_d   = pos_b_q;
    map_d     = map_q;
    swap_busy = 1'b0;
    swap_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (swap_req) begin
          pos_a_d = swap_pos_a;
          pos_b_d = swap_pos_b;
          state_d = ST_WAIT_VB;
        end
      end
      ST_WAIT_VB: begin
        swap_busy = 1'b1;
        if (32'(DrawY) >= V_ACTIVE) state_d = ST_SWAP;
      end
      ST_SWAP: begin
        // a == b falls out naturally: both writes carry the same value.
        swap_busy       = 1'b1;
        map_d[pos_a_q]  = map_q[pos_b_q];
        map_d[pos_b_q]  = map_q[pos_a_q];
        state_d         = ST_DONE;
      end
      ST_DONE: begin
        swap_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pos_a_q <= '0;
      pos_b_q <= '0;
      for (int i = 0; i < NUM_TILES; i++) map_q[i] <= TILE_ID_W'(i);
    end else begin
      state_q <= state_d;
      pos_a_q <= pos_a_d;
      pos_b_q <= pos_b_d;
      for (int i = 0; i < NUM_TILES; i++) map_q[i] <= map_d[i];
    end
  end

endmodule
